// File: rtl/gate_seq_pkg.sv
// Shared codes for the gate-lab stimulus sequencer: operation selects and FSM state encoding.
package gate_seq_pkg;

  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_NAND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Golden combinational gate: the value a correct gate-under-test must produce for a, b and mode.
module gate_ref_model
  import gate_seq_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    case (mode)
      MODE_AND:  expected = a & b;
      MODE_OR:   expected = a | b;
      MODE_XOR:  expected = a ^ b;
      MODE_NAND: expected = ~(a & b);
      default:   expected = '0;
    endcase
  end

endmodule

// File: rtl/gate_stim_seq.sv
// Sweeps every {b,a} operand pair into a gate-under-test, holds each for DWELL cycles and
// checks dut_c on the last dwell cycle, keeping a saturating error count and the first failure.
module gate_stim_seq
  import gate_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DWELL = 10,
  parameter int ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     dut_c,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_W-1:0]     err_cnt,
  output logic                 fail_vld,
  output logic [2*WIDTH-1:0]   fail_vec,
  output logic [WIDTH-1:0]     fail_c,
  output logic [1:0]           dbg_state
);

  localparam int                VW      = 2 * WIDTH;
  localparam int                DW      = $clog2(DWELL);
  localparam logic [DW-1:0]     D_LAST  = DW'(DWELL - 1);
  localparam logic [VW-1:0]     V_LAST  = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;

  state_e             state_q, state_d;
  logic [VW-1:0]      v_q, v_d;
  logic [DW-1:0]      d_q, d_d;
  logic [1:0]         mode_q, mode_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fvld_q, fvld_d;
  logic [VW-1:0]      fvec_q, fvec_d;
  logic [WIDTH-1:0]   fc_q, fc_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   exp_c;

  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a        (v_q[WIDTH-1:0]),
    .b        (v_q[VW-1:WIDTH]),
    .mode     (mode_q),
    .expected (exp_c)
  );

  // Handshake: start is a request taken only in IDLE (busy low); while busy or in DONE
  // start and mode are ignored, and abort is honoured only in DRIVE.
  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    d_d     = d_q;
    mode_d  = mode_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    fc_d    = fc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          v_d     = '0;
          d_d     = '0;
          mode_d  = mode;
          err_d   = '0;
          fvld_d  = 1'b0;
          fvec_d  = '0;
          fc_d    = '0;
        end
      end
      ST_DRIVE: begin
        d_d = d_q + 1'b1;
        if (d_q == D_LAST) begin
          if (dut_c != exp_c) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (!fvld_q) begin
              fvld_d = 1'b1;
              fvec_d = v_q;
              fc_d   = dut_c;
            end
          end
          d_d = '0;
          v_d = v_q + 1'b1;
          if (v_q == V_LAST) state_d = ST_DONE;
        end
        // Abort wins over completion, but a check landing on the same edge still counts.
        if (abort) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    a_d = '0;
    b_d = '0;
    if (state_d == ST_DRIVE) begin
      a_d = v_d[WIDTH-1:0];
      b_d = v_d[VW-1:WIDTH];
    end
    busy_d = (state_d == ST_DRIVE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      d_q     <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
      fc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      d_q     <= d_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
      fc_q    <= fc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_cnt   = err_q;
  assign fail_vld  = fvld_q;
  assign fail_vec  = fvec_q;
  assign fail_c    = fc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Bench for gate_stim_seq: an emulated gate-under-test with injectable faults, a sweep model
// that predicts the vector stream and final results, and a monitor that pops and compares.
module tb_gate_stim_seq;

  localparam int W      = 2;
  localparam int DWELL  = 3;
  localparam int ERR_W  = 4;
  localparam int VW     = 2 * W;
  localparam int NV     = 1 << VW;
  localparam int T      = NV * DWELL;
  localparam int ERR_MX = (1 << ERR_W) - 1;

  typedef struct {
    logic             done;
    logic [ERR_W-1:0] err;
    logic             fv;
    logic [VW-1:0]    vec;
    logic [W-1:0]     c;
  } res_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [W-1:0]     dut_c;
  logic [W-1:0]     a_out, b_out;
  logic             busy, done;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_vld;
  logic [VW-1:0]    fail_vec;
  logic [W-1:0]     fail_c;
  logic [1:0]       dbg_state;

  logic [VW-1:0]    exp_q[$];
  res_t             res_q[$];
  logic [W-1:0]     fault_tbl [NV];
  int               dut_kind;
  bit               mon_en;
  int               n_chk;
  int               n_pass;

  gate_stim_seq #(.WIDTH(W), .DWELL(DWELL), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .dut_c     (dut_c),
    .a_out     (a_out),
    .b_out     (b_out),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .fail_vld  (fail_vld),
    .fail_vec  (fail_vec),
    .fail_c    (fail_c),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] op_f(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    case (m)
      0:       return a & b;
      1:       return a | b;
      2:       return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Emulated gate-under-test: a gate of kind dut_kind, with optional per-vector bit flips.
  assign dut_c = op_f(dut_kind, a_out, b_out) ^ fault_tbl[{b_out, a_out}];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- driver ----------------
  task automatic run_sweep(input int m, input int kind, input bit clean, input int abort_at,
                           input bit disturb);
    int           n_busy, n_vec, err;
    logic         fv;
    logic [VW-1:0] fvec;
    logic [W-1:0] fc, ea, eb, want, got;
    res_t         r;
    for (int v = 0; v < NV; v++)
      fault_tbl[v] = (clean || $urandom_range(0, 3) != 0) ? '0 : W'($urandom_range(1, (1 << W) - 1));
    dut_kind = kind;
    n_busy = (abort_at > 0) ? abort_at : T;
    n_vec  = (abort_at > 0) ? abort_at / DWELL : NV;
    err = 0; fv = 1'b0; fvec = '0; fc = '0;
    for (int v = 0; v < n_vec; v++) begin
      ea   = W'(v % (1 << W));
      eb   = W'(v / (1 << W));
      want = op_f(m, ea, eb);
      got  = op_f(kind, ea, eb) ^ fault_tbl[v];
      if (got != want) begin
        if (err < ERR_MX) err++;
        if (!fv) begin
          fv = 1'b1; fvec = {eb, ea}; fc = got;
        end
      end
    end
    for (int j = 0; j < n_busy; j++) begin
      ea = W'((j / DWELL) % (1 << W));
      eb = W'((j / DWELL) / (1 << W));
      exp_q.push_back({eb, ea});
    end
    r.done = (abort_at == 0);
    r.err  = ERR_W'(err);
    r.fv   = fv;
    r.vec  = fvec;
    r.c    = fc;
    res_q.push_back(r);

    @(posedge clk); #1;
    mode  = 2'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_clear_on_start", err_cnt, 0);
    check("fail_clear_on_start", fail_vld, 0);
    check("busy_after_start", busy, 1);
    for (int i = 1; i < n_busy; i++) begin
      @(posedge clk); #1;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom_range(0, 3));
      end
    end
    if (abort_at > 0) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      check("idle_after_abort", busy, 0);
      check("ab_zero_after_abort", {b_out, a_out}, 0);
    end else begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("hold_err_cnt", err_cnt, err);
    check("hold_fail_vld", fail_vld, fv);
    check("hold_fail_vec", fail_vec, fvec);
    check("hold_state_idle", dbg_state, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [VW-1:0] e;
    res_t          r;
    bit            pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        pb = 1'b0;
        continue;
      end
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", busy, 0);
        end else begin
          e = exp_q.pop_front();
          check("vector", {b_out, a_out}, e);
        end
      end else if (pb) begin
        if (res_q.size() == 0) begin
          check("unexpected_end", 1, 0);
        end else begin
          r = res_q.pop_front();
          check("done_pulse", done, r.done);
          check("err_cnt", err_cnt, r.err);
          check("fail_vld", fail_vld, r.fv);
          check("fail_vec", fail_vec, r.vec);
          check("fail_c", fail_c, r.c);
          check("ab_zero_at_end", {b_out, a_out}, 0);
        end
      end else begin
        check("stray_done", done, 0);
      end
      pb = busy;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_chk = 0; n_pass = 0;
    mon_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    dut_kind = 0;
    for (int v = 0; v < NV; v++) fault_tbl[v] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_a_b", {b_out, a_out}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_cnt, 0);
    check("rst_fail_vld", fail_vld, 0);
    check("rst_fail_vec", fail_vec, 0);
    check("rst_fail_c", fail_c, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_sweep(0, 0, 1'b1, 0, 1'b0);        // AND vs correct AND
    run_sweep(2, 1, 1'b1, 0, 1'b0);        // XOR vs OR: a&b != 0 mismatches
    run_sweep(3, 0, 1'b1, 0, 1'b1);        // NAND vs AND: every vector wrong, saturates
    run_sweep(3, 0, 1'b1, 5, 1'b0);        // abort mid-dwell
    run_sweep(3, 0, 1'b1, 2 * DWELL, 1'b0);// abort on a check edge
    run_sweep(0, 0, 1'b1, 0, 1'b0);        // new start clears partial results
    for (int k = 0; k < 10; k++)
      run_sweep($urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, T - 1) : 0, 1'b1);

    // Asynchronous reset in the middle of a faulty sweep.
    mon_en = 1'b0;
    dut_kind = 2;
    @(posedge clk); #1;
    mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_a_b", {b_out, a_out}, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_fail_vld", fail_vld, 0);
    check("midrst_fail_vec", fail_vec, 0);
    check("midrst_fail_c", fail_c, 0);
    check("midrst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_sweep(1, 1, 1'b1, 0, 1'b0);        // recovery after reset

    repeat (5) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
